// File: rtl/dht11_sensor_emulator.sv
// DHT11 responder: waits for a host start pulse on an open-drain line, then answers with the
// response preamble and a 40-bit humidity/temperature frame. It only drives low or releases.
module dht11_sensor_emulator #(
  parameter int unsigned CYCLES_PER_US = 50,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned RESP_LOW_US   = 80,
  parameter int unsigned RESP_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  inout  wire        transmission_line,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic       corrupt_checksum,
  output logic       busy,
  output logic       frame_done,
  output logic       start_rejected
);

  localparam logic [23:0] StartMinCyc  = 24'(START_MIN_US * CYCLES_PER_US);
  localparam logic [23:0] RespDelayCyc = 24'(RESP_DELAY_US * CYCLES_PER_US);
  localparam logic [23:0] RespLowCyc   = 24'(RESP_LOW_US * CYCLES_PER_US);
  localparam logic [23:0] RespHighCyc  = 24'(RESP_HIGH_US * CYCLES_PER_US);
  localparam logic [23:0] BitLowCyc    = 24'(BIT_LOW_US * CYCLES_PER_US);
  localparam logic [23:0] Bit0HighCyc  = 24'(BIT0_HIGH_US * CYCLES_PER_US);
  localparam logic [23:0] Bit1HighCyc  = 24'(BIT1_HIGH_US * CYCLES_PER_US);
  localparam logic [23:0] CntMax       = 24'hFF_FFFF;
  // Our own low drive is still visible in the synchronizer for two cycles after release.
  localparam logic [23:0] EchoHoldoff  = 24'd2;
  localparam logic [5:0]  LastBit      = 6'd39;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StRespWait,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } state_e;

  state_e      r_state, w_state_next;
  logic        r_sync1, r_sync2;
  logic [23:0] r_cnt, w_cnt_next;
  logic [23:0] w_dur;
  logic        w_expired;
  logic [5:0]  r_bit_idx, w_bit_idx_next;
  logic [39:0] r_shift, w_shift_next;
  logic        r_frame_done, w_frame_done_next;
  logic        r_start_rejected, w_start_rejected_next;
  logic        w_drive_low;
  logic [7:0]  w_sum, w_checksum;

  assign w_sum      = hum_int + hum_float + temp_int + temp_float;
  assign w_checksum = corrupt_checksum ? ~w_sum : w_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1          <= 1'b1;
      r_sync2          <= 1'b1;
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_bit_idx        <= '0;
      r_shift          <= '0;
      r_frame_done     <= 1'b0;
      r_start_rejected <= 1'b0;
    end else begin
      r_sync1          <= transmission_line;
      r_sync2          <= r_sync1;
      r_state          <= w_state_next;
      r_cnt            <= w_cnt_next;
      r_bit_idx        <= w_bit_idx_next;
      r_shift          <= w_shift_next;
      r_frame_done     <= w_frame_done_next;
      r_start_rejected <= w_start_rejected_next;
    end
  end

  always_comb begin
    w_dur = '0;
    unique case (r_state)
      StRespWait:         w_dur = RespDelayCyc;
      StRespLow:          w_dur = RespLowCyc;
      StRespHigh:         w_dur = RespHighCyc;
      StBitLow, StEndLow: w_dur = BitLowCyc;
      StBitHigh:          w_dur = r_shift[0] ? Bit1HighCyc : Bit0HighCyc;
      default:            w_dur = '0;
    endcase
  end

  assign w_expired = (r_cnt + 24'd1) >= w_dur;

  always_comb begin
    w_state_next          = r_state;
    w_cnt_next            = r_cnt;
    w_bit_idx_next        = r_bit_idx;
    w_shift_next          = r_shift;
    w_frame_done_next     = 1'b0;
    w_start_rejected_next = 1'b0;
    w_drive_low           = 1'b0;
    busy                  = 1'b1;

    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (r_cnt < EchoHoldoff) begin
          w_cnt_next = r_cnt + 24'd1;
        end else if (enable && !r_sync2) begin
          w_state_next = StStartLow;
          w_cnt_next   = '0;
        end
      end

      StStartLow: begin
        busy = 1'b0;
        if (!r_sync2) begin
          if (r_cnt != CntMax) w_cnt_next = r_cnt + 24'd1;
        end else begin
          w_cnt_next = '0;
          // The low sample seen in idle is part of the pulse, hence the minus one.
          if (r_cnt >= StartMinCyc - 24'd1) begin
            w_shift_next = {w_checksum, temp_float, temp_int, hum_float, hum_int};
            w_state_next = StRespWait;
          end else begin
            w_start_rejected_next = 1'b1;
            w_state_next          = StIdle;
          end
        end
      end

      StRespWait: begin
        w_cnt_next = r_cnt + 24'd1;
        if (w_expired) begin
          w_state_next = StRespLow;
          w_cnt_next   = '0;
        end
      end

      StRespLow: begin
        w_drive_low = 1'b1;
        w_cnt_next  = r_cnt + 24'd1;
        if (w_expired) begin
          w_state_next = StRespHigh;
          w_cnt_next   = '0;
        end
      end

      StRespHigh: begin
        w_cnt_next = r_cnt + 24'd1;
        if (w_expired) begin
          w_state_next   = StBitLow;
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
        end
      end

      StBitLow: begin
        w_drive_low = 1'b1;
        w_cnt_next  = r_cnt + 24'd1;
        if (w_expired) begin
          w_state_next = StBitHigh;
          w_cnt_next   = '0;
        end
      end

      StBitHigh: begin
        w_cnt_next = r_cnt + 24'd1;
        if (w_expired) begin
          w_cnt_next   = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == LastBit) begin
            w_state_next = StEndLow;
          end else begin
            w_bit_idx_next = r_bit_idx + 6'd1;
            w_state_next   = StBitLow;
          end
        end
      end

      StEndLow: begin
        w_drive_low = 1'b1;
        w_cnt_next  = r_cnt + 24'd1;
        if (w_expired) begin
          w_state_next      = StIdle;
          w_cnt_next        = '0;
          w_frame_done_next = 1'b1;
        end
      end

      default: begin
        busy         = 1'b0;
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign transmission_line = w_drive_low ? 1'b0 : 1'bz;
  assign frame_done        = r_frame_done;
  assign start_rejected    = r_start_rejected;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Bench for dht11_sensor_emulator: a host model pulses the line, the observed waveform is
// reduced to run lengths and compared with a run list derived from the frame contents.
module tb_dht11_sensor_emulator;

  localparam int StartMin  = 400;
  localparam int RespDelay = 30;
  localparam int RespLow   = 80;
  localparam int RespHigh  = 80;
  localparam int BitLow    = 50;
  localparam int Bit0High  = 26;
  localparam int Bit1High  = 70;
  localparam int SyncLat   = 3;  // two synchronizer flops plus the state register
  localparam int MaxFrame  = 6000;

  typedef int run_q_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = '0, hum_float = '0, temp_int = '0, temp_float = '0;
  logic       corrupt_checksum = 1'b0;
  logic       busy, frame_done, start_rejected;
  wire        line;

  pullup (line);
  assign line = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emulator #(
    .CYCLES_PER_US(1),
    .START_MIN_US (StartMin),
    .RESP_DELAY_US(RespDelay),
    .RESP_LOW_US  (RespLow),
    .RESP_HIGH_US (RespHigh),
    .BIT_LOW_US   (BitLow),
    .BIT0_HIGH_US (Bit0High),
    .BIT1_HIGH_US (Bit1High)
  ) u_dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .transmission_line(line),
    .hum_int          (hum_int),
    .hum_float        (hum_float),
    .temp_int         (temp_int),
    .temp_float       (temp_float),
    .corrupt_checksum (corrupt_checksum),
    .busy             (busy),
    .frame_done       (frame_done),
    .start_rejected   (start_rejected)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     failures = 0;
  run_q_t cap_runs;
  int     cap_done, cap_rej, cap_busy_err;
  bit     cap_timeout;

  function automatic logic [39:0] model_frame(input logic [7:0] hi, input logic [7:0] hf,
                                              input logic [7:0] ti, input logic [7:0] tf,
                                              input logic corrupt);
    int sum;
    logic [7:0] cs;
    sum = (int'(hi) + int'(hf) + int'(ti) + int'(tf)) % 256;
    cs  = corrupt ? 8'(255 - sum) : 8'(sum);
    return {cs, tf, ti, hf, hi};
  endfunction

  // Positive entries are released (high) runs, negative entries are driven-low runs.
  function automatic run_q_t model_runs(input logic [39:0] f);
    run_q_t q;
    q.push_back(RespDelay + SyncLat);
    q.push_back(-RespLow);
    q.push_back(RespHigh);
    for (int i = 0; i < 40; i++) begin
      q.push_back(-BitLow);
      q.push_back(f[i] ? Bit1High : Bit0High);
    end
    q.push_back(-BitLow);
    q.push_back(1);
    return q;
  endfunction

  function automatic int first_diff(input run_q_t a, input run_q_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int get_run(input run_q_t q, input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 0;
  endfunction

  function automatic logic [39:0] decode_runs(input run_q_t r);
    logic [39:0] f;
    f = '0;
    for (int i = 0; i < 40; i++) if (4 + 2 * i < r.size()) f[i] = (r[4 + 2 * i] > 48);
    return f;
  endfunction

  task automatic host_pulse(input int len);
    @(posedge clock);
    #1 host_low = 1'b1;
    repeat (len) @(posedge clock);
    #1 host_low = 1'b0;
  endtask

  task automatic randomize_inputs();
    hum_int          = 8'($urandom);
    hum_float        = 8'($urandom);
    temp_int         = 8'($urandom);
    temp_float       = 8'($urandom);
    corrupt_checksum = 1'($urandom);
  endtask

  // mode 1: change every data input once busy is seen; mode 2: toggle enable every cycle.
  task automatic capture(input bit expect_frame, input int max_cyc, input int mode);
    int   run;
    logic lvl, l, exp_busy;
    bit   mutated;
    cap_runs.delete();
    cap_done = 0; cap_rej = 0; cap_busy_err = 0; cap_timeout = 1'b0;
    run = 0; lvl = 1'b1; mutated = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clock);
      l = (line === 1'b0) ? 1'b0 : 1'b1;
      if (run > 0 && l !== lvl) begin
        cap_runs.push_back(lvl ? run : -run);
        run = 0;
      end
      lvl = l;
      run++;
      if (frame_done === 1'b1) cap_done++;
      if (start_rejected === 1'b1) cap_rej++;
      exp_busy = expect_frame && (n >= SyncLat) && (cap_done == 0);
      if (busy !== exp_busy) cap_busy_err++;
      if (mode == 1 && busy === 1'b1 && !mutated) begin
        mutated = 1'b1;
        randomize_inputs();
        temp_int         = 8'h42;
        corrupt_checksum = ~corrupt_checksum;
      end
      if (mode == 2) enable = 1'($urandom);
      if (expect_frame && cap_done > 0) break;
    end
    cap_runs.push_back(lvl ? run : -run);
    if (expect_frame && cap_done == 0) cap_timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if (line !== 1'b1) begin failures++; $display("FAIL reset_line got %b required 1", line); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got %b required 0", frame_done);
    end
    checks++;
    if (start_rejected !== 1'b0) begin
      failures++; $display("FAIL reset_start_rejected got %b required 0", start_rejected);
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_nominal();
    run_q_t exp_q;
    int d;
    hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h05;
    corrupt_checksum = 1'b0;
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, 1'b0));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 0);
    d = first_diff(cap_runs, exp_q);
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL nominal_wave run[%0d] got %0d required %0d (runs %0d/%0d timeout=%0b)", d,
               get_run(cap_runs, d), get_run(exp_q, d), cap_runs.size(), exp_q.size(),
               cap_timeout);
    end
    checks++;
    if (decode_runs(cap_runs) !== 40'h55_05_19_00_37) begin
      failures++;
      $display("FAIL nominal_decode got %h required 5505190037", decode_runs(cap_runs));
    end
    checks++;
    if (cap_busy_err != 0) begin
      failures++; $display("FAIL nominal_busy got %0d bad cycles required 0", cap_busy_err);
    end
    capture(1'b0, 200, 0);
    checks++;
    if (cap_done != 0 || cap_rej != 0) begin
      failures++;
      $display("FAIL nominal_quiet got done=%0d rej=%0d required 0/0", cap_done, cap_rej);
    end
  endtask

  task automatic test_random_frames();
    run_q_t exp_q;
    int d;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float,
                                     corrupt_checksum));
      host_pulse(int'($urandom_range(StartMin + 300, StartMin)));
      capture(1'b1, MaxFrame, 0);
      d = first_diff(cap_runs, exp_q);
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL random_wave[%0d] run[%0d] got %0d required %0d", k, d,
                 get_run(cap_runs, d), get_run(exp_q, d));
      end
      checks++;
      if (cap_busy_err != 0 || cap_rej != 0) begin
        failures++;
        $display("FAIL random_flags[%0d] got busy_err=%0d rej=%0d required 0/0", k,
                 cap_busy_err, cap_rej);
      end
    end
  endtask

  task automatic test_short_start();
    run_q_t exp_q;
    int d, len;
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? StartMin - 1 : int'($urandom_range(StartMin - 2, 1));
      host_pulse(len);
      capture(1'b0, 100, 0);
      checks++;
      if (cap_runs.size() != 1 || cap_runs[0] != 100) begin
        failures++;
        $display("FAIL short_line len=%0d got runs=%0d first=%0d required 1/100", len,
                 cap_runs.size(), cap_runs[0]);
      end
      checks++;
      if (cap_rej != 1) begin
        failures++; $display("FAIL short_rejected len=%0d got %0d required 1", len, cap_rej);
      end
      checks++;
      if (cap_busy_err != 0) begin
        failures++; $display("FAIL short_busy len=%0d got %0d required 0", len, cap_busy_err);
      end
    end
    randomize_inputs();
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 0);
    d = first_diff(cap_runs, exp_q);
    checks++;
    if (d != -1 || cap_rej != 0) begin
      failures++;
      $display("FAIL short_then_accept run[%0d] got %0d required %0d rej=%0d", d,
               get_run(cap_runs, d), get_run(exp_q, d), cap_rej);
    end
  endtask

  task automatic test_checksum();
    run_q_t exp_q;
    int d;
    logic [7:0] want;
    for (int c = 0; c < 2; c++) begin
      hum_int = 8'hFF; hum_float = 8'hFF; temp_int = 8'hFF; temp_float = 8'h03;
      corrupt_checksum = (c == 1);
      want = (c == 1) ? 8'hFF : 8'h00;
      exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float,
                                     corrupt_checksum));
      host_pulse(StartMin);
      capture(1'b1, MaxFrame, 0);
      d = first_diff(cap_runs, exp_q);
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL checksum_wave[%0d] run[%0d] got %0d required %0d", c, d,
                 get_run(cap_runs, d), get_run(exp_q, d));
      end
      checks++;
      if (decode_runs(cap_runs) >> 32 !== 40'(want)) begin
        failures++;
        $display("FAIL checksum_byte[%0d] got %h required %h", c,
                 decode_runs(cap_runs) >> 32, want);
      end
    end
  endtask

  task automatic test_snapshot();
    run_q_t exp_q;
    int d;
    logic [39:0] got;
    randomize_inputs();
    temp_int = 8'h19;
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 1);
    d = first_diff(cap_runs, exp_q);
    got = decode_runs(cap_runs);
    checks++;
    if (d != -1 || got[23:16] !== 8'h19) begin
      failures++;
      $display("FAIL snapshot_inflight run[%0d] got %0d required %0d temp=%h required 19", d,
               get_run(cap_runs, d), get_run(exp_q, d), got[23:16]);
    end
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 0);
    d = first_diff(cap_runs, exp_q);
    got = decode_runs(cap_runs);
    checks++;
    if (d != -1 || got[23:16] !== 8'h42) begin
      failures++;
      $display("FAIL snapshot_next run[%0d] got %0d required %0d temp=%h required 42", d,
               get_run(cap_runs, d), get_run(exp_q, d), got[23:16]);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_q_t exp_q;
    int d, off, done_seen;
    randomize_inputs();
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    off = 0;
    for (int i = 0; i < 37; i++) off += (exp_q[i] < 0) ? -exp_q[i] : exp_q[i];
    done_seen = 0;
    host_pulse(StartMin);
    for (int n = 0; n <= off + 25; n++) begin
      @(negedge clock);
      if (frame_done === 1'b1) done_seen++;
    end
    checks++;
    if (line !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got line=%b busy=%b required 0/1", line, busy);
    end
    reset = 1'b1;
    @(negedge clock);
    if (frame_done === 1'b1) done_seen++;
    checks++;
    if (line !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_post got line=%b busy=%b required 1/0", line, busy);
    end
    reset = 1'b0;
    capture(1'b0, 300, 0);
    checks++;
    if (done_seen + cap_done != 0 || cap_rej != 0 || cap_runs.size() != 1) begin
      failures++;
      $display("FAIL midreset_quiet got done=%0d rej=%0d runs=%0d required 0/0/1",
               done_seen + cap_done, cap_rej, cap_runs.size());
    end
    randomize_inputs();
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 0);
    d = first_diff(cap_runs, exp_q);
    checks++;
    if (d != -1 || cap_busy_err != 0) begin
      failures++;
      $display("FAIL midreset_recover run[%0d] got %0d required %0d busy_err=%0d", d,
               get_run(cap_runs, d), get_run(exp_q, d), cap_busy_err);
    end
  endtask

  task automatic test_enable();
    run_q_t exp_q;
    int d;
    enable = 1'b0;
    host_pulse(StartMin);
    capture(1'b0, 100, 0);
    checks++;
    if (cap_runs.size() != 1 || cap_rej != 0 || cap_busy_err != 0) begin
      failures++;
      $display("FAIL enable_gated got runs=%0d rej=%0d busy_err=%0d required 1/0/0",
               cap_runs.size(), cap_rej, cap_busy_err);
    end
    enable = 1'b1;
    randomize_inputs();
    exp_q = model_runs(model_frame(hum_int, hum_float, temp_int, temp_float, corrupt_checksum));
    host_pulse(StartMin);
    capture(1'b1, MaxFrame, 2);
    enable = 1'b1;
    d = first_diff(cap_runs, exp_q);
    checks++;
    if (d != -1 || cap_busy_err != 0) begin
      failures++;
      $display("FAIL enable_toggle run[%0d] got %0d required %0d busy_err=%0d", d,
               get_run(cap_runs, d), get_run(exp_q, d), cap_busy_err);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got time limit reached required finish before %0t", $time);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_random_frames();
    test_short_start();
    test_checksum();
    test_snapshot();
    test_reset_mid_frame();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
